stdout_display_fifo: RTL and testbench

- Buffers values the processor writes to its stdout address and shows them one at a time on an NDIG-digit decimal display.
- Structure: DEPTH-entry FIFO, then a sequential double-dabble binary-to-BCD converter, then a hold timer that keeps each value visible for HOLD_CYC cycles.
- Replaces the single-register display buffer: stores are no longer lost when they arrive faster than a human can read them.

---
 rtl/stdout_pkg.sv | 29 ++
 rtl/bcd_dd_step.sv | 35 +++
 rtl/stdout_display_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_stdout_display_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdout_pkg.sv
// ---------------------------------------------------------------------------
// stdout_pkg
// Shared definitions for the stdout display FIFO.
//   state_t  : controller states (IDLE, CONV, HOLD)
//   BCD_NINE : digit value shown in every position when a word cannot be
//              represented on the display
//   pow10()  : elaboration-time power of ten, used to build the display limit
// ---------------------------------------------------------------------------
package stdout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // 10^n as a 64-bit constant; callers truncate to the width they need.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// ---------------------------------------------------------------------------
// bcd_dd_step
// One combinational double-dabble step over NDIG packed BCD digits:
// every digit >= 5 gets 3 added, then the whole accumulator is shifted left
// by one with shift_in entering the units digit. The bit leaving the top
// digit is dropped.
//   acc_in   [4*NDIG-1:0] : accumulator before the step
//   shift_in              : next binary bit, MSB first
//   acc_out  [4*NDIG-1:0] : accumulator after adjust and shift
// ---------------------------------------------------------------------------
module bcd_dd_step #(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] acc_in,
  input  logic              shift_in,
  output logic [4*NDIG-1:0] acc_out
);

  logic [4*NDIG-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (acc_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_in[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = acc_in[4*i +: 4];
      end
    end
  end

  // The explicit truncation discards the carry out of the top digit.
  assign acc_out = (4*NDIG)'({adj, shift_in});

endmodule

// File: rtl/stdout_display_fifo.sv
// ---------------------------------------------------------------------------
// stdout_display_fifo
// Buffers words written to the processor's stdout address and shows them one
// at a time on an NDIG-digit decimal display. A DEPTH-entry FIFO feeds a
// sequential double-dabble converter; each converted value is then held for
// HOLD_CYC cycles before the next word is popped.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   wr_en        : push request (stdout store strobe)
//   wr_data      : word to push (unsigned, DATA_W bits)
//   clr_ovf      : synchronous clear of ovf
//   full         : FIFO holds DEPTH entries
//   empty        : FIFO holds no entries
//   count        : FIFO occupancy
//   ovf          : sticky, a push was dropped while full
//   bcd          : displayed digits, units in bcd[3:0]
//   disp_valid   : bcd holds a converted value
//   out_of_range : displayed word was >= 10^NDIG (bcd shows all nines)
//   busy         : controller is converting or holding
// ---------------------------------------------------------------------------
module stdout_display_fifo
  import stdout_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int NDIG     = 4,
  parameter int HOLD_CYC = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [4*NDIG-1:0]        bcd,
  output logic                     disp_valid,
  output logic                     out_of_range,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [DATA_W:0] LIMIT     = (DATA_W+1)'(pow10(NDIG));
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [BW-1:0]   BITS_C    = BW'(DATA_W);
  localparam logic [TW-1:0]   HOLD_LOAD = TW'(HOLD_CYC - 1);

  // Replace an unrepresentable value with all nines on the display.
  function automatic logic [4*NDIG-1:0] sat_bcd(input logic [4*NDIG-1:0] acc_v,
                                                input logic              over);
    if (over) begin
      return {NDIG{BCD_NINE}};
    end
    return acc_v;
  endfunction

  // FIFO state
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              drop;

  // Controller and converter state
  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] sr;
  logic [4*NDIG-1:0] acc;
  logic [4*NDIG-1:0] acc_step;
  logic [BW-1:0]     bitcnt;
  logic [TW-1:0]     timer;
  logic              range_flag;
  logic              conv_shift;
  logic              conv_done;

  assign head = mem[rd_ptr];

  // Pop only from the registered empty flag, so an empty FIFO can never
  // see a same-cycle push and pop.
  assign pop  = (state == IDLE) && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  assign conv_shift = (state == CONV) && (bitcnt != '0);
  assign conv_done  = (state == CONV) && (bitcnt == '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // ---- FIFO control: pointers, occupancy, flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      // A dropped push outranks a simultaneous clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---- Controller: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)        state_nxt = CONV;
      CONV:    if (bitcnt == '0)  state_nxt = HOLD;
      HOLD:    if (timer == '0)   state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // ---- Converter datapath: one adjust-and-shift per CONV cycle ----
  bcd_dd_step #(
    .NDIG (NDIG)
  ) u_step (
    .acc_in   (acc),
    .shift_in (sr[DATA_W-1]),
    .acc_out  (acc_step)
  );

  always_ff @(posedge clk) begin
    if (pop) begin
      sr  <= head;
      acc <= '0;
    end else if (conv_shift) begin
      sr  <= {sr[DATA_W-2:0], 1'b0};
      acc <= acc_step;
    end
  end

  // ---- Converter control, display registers and hold timer ----
  // The cycle after the last shift (counter already at zero) latches the
  // result, so bcd updates DATA_W+1 edges after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt       <= '0;
      timer        <= '0;
      range_flag   <= 1'b0;
      bcd          <= '0;
      disp_valid   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      if (pop) begin
        bitcnt     <= BITS_C;
        range_flag <= ({1'b0, head} >= LIMIT);
      end
      if (conv_shift) begin
        bitcnt <= bitcnt - BW'(1);
      end
      if (conv_done) begin
        bcd          <= sat_bcd(acc, range_flag);
        disp_valid   <= 1'b1;
        out_of_range <= range_flag;
        timer        <= HOLD_LOAD;
      end
      if ((state == HOLD) && (timer != '0)) begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stdout_display_fifo.sv
module tb_stdout_display_fifo;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int NDIG     = 4;
  localparam int HOLD_CYC = 5;
  localparam int CONV_LAT = DATA_W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        clr_ovf = 1'b0;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;
  logic [15:0] bcd;
  logic        disp_valid;
  logic        out_of_range;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int conv_cnt = -1;
  int maxc = 0;
  logic busy_prev = 1'b0;
  logic [16:0] mon_e;
  logic [16:0] exp_q [$];

  typedef struct {
    logic [31:0] v;
    logic [15:0] b;
    logic        o;
  } vec_t;
  vec_t tbl [8];

  logic [31:0] wrap_vals [10];

  stdout_display_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NDIG     (NDIG),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_ovf      (clr_ovf),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .bcd          (bcd),
    .disp_valid   (disp_valid),
    .out_of_range (out_of_range),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference conversion by decimal division, independent of double-dabble.
  function automatic logic [16:0] model(input logic [31:0] v);
    logic [15:0] d;
    logic [31:0] t;
    if (v >= 32'd10000) return {1'b1, 16'h9999};
    t = v;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v, input bit accept);
    wr_en = 1'b1;
    wr_data = v;
    if (accept) exp_q.push_back(model(v));
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input int bound);
    int n;
    n = 0;
    while (!busy) begin
      if (n >= bound) begin
        checks++;
        failures++;
        $display("FAIL wait_busy: busy=%b required 1 within %0d cycles", busy, bound);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (busy || !empty || conv_cnt >= 0) begin
      if (n >= bound) begin
        checks++;
        failures++;
        $display("FAIL wait_drain: busy=%b empty=%b required idle/empty within %0d cycles",
                 busy, empty, bound);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Scoreboard: a pop shows up as busy rising; the display must update
  // exactly CONV_LAT edges later with the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (int'(count) > maxc) maxc = int'(count);
    if (rst) begin
      conv_cnt = -1;
      busy_prev = 1'b0;
    end else begin
      if (conv_cnt >= 0) conv_cnt++;
      if (conv_cnt == CONV_LAT) begin
        conv_cnt = -1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL disp_unexpected: bcd=%h with no value queued", bcd);
        end else begin
          mon_e = exp_q.pop_front();
          chk("disp_bcd", {16'h0, bcd}, {16'h0, mon_e[15:0]});
          chk("disp_oor", {31'h0, out_of_range}, {31'h0, mon_e[16]});
          chk("disp_valid", {31'h0, disp_valid}, 32'd1);
        end
      end
      if (busy && !busy_prev) conv_cnt = 0;
      busy_prev = busy;
    end
  end

  initial begin
    tbl[0] = '{32'd10000,      16'h9999, 1'b1};
    tbl[1] = '{32'd7,          16'h0007, 1'b0};
    tbl[2] = '{32'd0,          16'h0000, 1'b0};
    tbl[3] = '{32'd9999,       16'h9999, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF,  16'h9999, 1'b1};
    tbl[5] = '{32'd5080,       16'h5080, 1'b0};
    tbl[6] = '{32'd10001,      16'h9999, 1'b1};
    tbl[7] = '{32'd361,        16'h0361, 1'b0};

    wrap_vals = '{32'd0, 32'd9, 32'd99, 32'd999, 32'd4095,
                  32'd1, 32'd42, 32'd9998, 32'd123, 32'd10000};

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    chk("rst_bcd", {16'h0, bcd}, 32'd0);
    chk("rst_dv", {31'h0, disp_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Single value with exact latency
    push(32'd1234, 1'b1);
    wait_busy(5);
    tick();
    chk("single_busy_t1", {31'h0, busy}, 32'd1);
    repeat (31) tick();
    chk("single_bcd_early", {16'h0, bcd}, 32'd0);
    tick();
    chk("single_bcd", {16'h0, bcd}, 32'h1234);
    chk("single_dv", {31'h0, disp_valid}, 32'd1);
    chk("single_oor", {31'h0, out_of_range}, 32'd0);
    repeat (4) tick();
    chk("single_busy_hold_end", {31'h0, busy}, 32'd1);
    tick();
    chk("single_busy_idle", {31'h0, busy}, 32'd0);
    chk("single_bcd_retained", {16'h0, bcd}, 32'h1234);
    wait_drain(100);

    // Table-driven conversions including saturation
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].v, 1'b1);
      wait_drain(200);
      chk("tbl_bcd", {16'h0, bcd}, {16'h0, tbl[i].b});
      chk("tbl_oor", {31'h0, out_of_range}, {31'h0, tbl[i].o});
      chk("tbl_dv", {31'h0, disp_valid}, 32'd1);
    end

    // Asynchronous reset in the middle of a conversion
    push(32'd1234, 1'b0);
    wait_busy(5);
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_bcd", {16'h0, bcd}, 32'd0);
    chk("arst_dv", {31'h0, disp_valid}, 32'd0);
    chk("arst_oor", {31'h0, out_of_range}, 32'd0);
    chk("arst_empty", {31'h0, empty}, 32'd1);
    chk("arst_count", {29'h0, count}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("arst_rel_empty", {31'h0, empty}, 32'd1);
    chk("arst_rel_bcd", {16'h0, bcd}, 32'd0);
    chk("arst_rel_busy", {31'h0, busy}, 32'd0);

    // Overflow: six back-to-back pushes from IDLE
    for (int i = 1; i <= 6; i++) begin
      push(32'(i), i <= 5);
      if (i == 5) begin
        chk("ovf_full5", {31'h0, full}, 32'd1);
        chk("ovf_count5", {29'h0, count}, 32'd4);
        chk("ovf_flag5", {31'h0, ovf}, 32'd0);
      end
    end
    chk("ovf_flag6", {31'h0, ovf}, 32'd1);
    chk("ovf_count6", {29'h0, count}, 32'd4);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'h0, ovf}, 32'd0);
    wait_drain(1000);

    // Pointer wrap over several fill/drain rounds
    maxc = 0;
    for (int i = 0; i < 4; i++) push(wrap_vals[i], 1'b1);
    chk("wrap_count_fill", {29'h0, count}, 32'd3);
    wait_drain(1000);
    for (int i = 4; i < 7; i++) push(wrap_vals[i], 1'b1);
    wait_drain(1000);
    for (int i = 7; i < 10; i++) push(wrap_vals[i], 1'b1);
    wait_drain(1000);
    chk("wrap_max_count", {31'h0, maxc <= 4}, 32'd1);
    chk("wrap_last_bcd", {16'h0, bcd}, 32'h9999);

    // Push and pop in the same cycle while full
    for (int i = 1; i <= 5; i++) push(32'(11 * i), 1'b1);
    chk("sim_full", {31'h0, full}, 32'd1);
    begin
      int n;
      n = 0;
      while (busy && n < 200) begin
        tick();
        n++;
      end
    end
    chk("sim_idle_reached", {31'h0, busy}, 32'd0);
    push(32'd66, 1'b1);
    chk("sim_count", {29'h0, count}, 32'd4);
    chk("sim_full_after", {31'h0, full}, 32'd1);
    chk("sim_ovf", {31'h0, ovf}, 32'd0);
    chk("sim_busy", {31'h0, busy}, 32'd1);
    wait_drain(1500);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("final_bcd", {16'h0, bcd}, 32'h0066);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
